axi_stream_split_s2m: RTL and testbench

AXI_STREAM_SPLIT_S2M -- requirements
Module: axi_stream_split_s2m

---
 rtl/axi_stream_split_s2m_if.sv | 32 +++
 rtl/axi_stream_split_s2m.sv | 69 ++++++
 tb/tb_axi_stream_split_s2m.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_split_s2m_if.sv
// AXI-Stream bundle used by the stream splitter.
// Master drives payload and valid; slave drives ready.
interface axi_stream_split_s2m_if #(
  parameter int DSIZE = 32,
  parameter int KSIZE = DSIZE / 8,
  parameter int USIZE = 1
);
  logic [DSIZE-1:0] tdata;
  logic [KSIZE-1:0] tkeep;
  logic [USIZE-1:0] tuser;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axi_stream_split_s2m.sv
// Splits each packet: first split_len beats to m0 (tlast forced
// on the last of them), remaining beats to m1. Zero-latency routing.
module axi_stream_split_s2m #(
  parameter int DSIZE = 32,
  parameter int KSIZE = DSIZE / 8,
  parameter int USIZE = 1
) (
  input  logic                          aclk,
  input  logic                          rst,
  input  logic [15:0]                   split_len,
  axi_stream_split_s2m_if.slave         s,
  axi_stream_split_s2m_if.master        m0,
  axi_stream_split_s2m_if.master        m1
);

  typedef enum logic {
    HEAD = 1'b0,
    TAIL = 1'b1
  } state_t;

  state_t           state;
  logic [15:0]      tcnt;
  logic             fire;
  logic             split_pt;
  logic [DSIZE-1:0] data;
  logic [KSIZE-1:0] keep;
  logic [USIZE-1:0] user;

  // split_len==0 would alias 0xFFFF; treat it as "never split"
  assign split_pt = (split_len != 16'd0)
                 && (tcnt == split_len - 16'd1);

  assign s.tready = (state == TAIL) ? m1.tready
                                    : m0.tready;
  assign fire = s.tvalid & s.tready;

  assign data = s.tdata;
  assign keep = s.tkeep;
  assign user = s.tuser;

  assign m0.tdata  = data;
  assign m0.tkeep  = keep;
  assign m0.tuser  = user;
  assign m0.tvalid = s.tvalid & (state == HEAD);
  assign m0.tlast  = s.tlast | split_pt;

  assign m1.tdata  = data;
  assign m1.tkeep  = keep;
  assign m1.tuser  = user;
  assign m1.tvalid = s.tvalid & (state == TAIL);
  assign m1.tlast  = s.tlast;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state <= HEAD;
      tcnt  <= 16'd0;
    end else if (fire) begin
      if (s.tlast) begin
        state <= HEAD;
        tcnt  <= 16'd0;
      end else begin
        tcnt <= tcnt + 16'd1;
        if (split_pt)
          state <= TAIL;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_split_s2m.sv
// Randomized directed bench for axi_stream_split_s2m.
// Routing expectations come from beat index vs split_len arithmetic.
module tb_axi_stream_split_s2m;

  logic        aclk = 1'b0;
  logic        rst;
  logic [15:0] split_len;

  always #5 aclk = ~aclk;

  axi_stream_split_s2m_if #(32, 4, 1) s_if ();
  axi_stream_split_s2m_if #(32, 4, 1) m0_if ();
  axi_stream_split_s2m_if #(32, 4, 1) m1_if ();

  axi_stream_split_s2m #(
    .DSIZE(32),
    .KSIZE(4),
    .USIZE(1)
  ) dut (
    .aclk      (aclk),
    .rst       (rst),
    .split_len (split_len),
    .s         (s_if),
    .m0        (m0_if),
    .m1        (m1_if)
  );

  int checks   = 0;
  int failures = 0;
  int mon0     = 0;
  int mon1     = 0;

  // independent handshake monitor on the outputs
  always @(posedge aclk) begin
    if (!rst) begin
      if (m0_if.tvalid && m0_if.tready) mon0++;
      if (m1_if.tvalid && m1_if.tready) mon1++;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends nsend beats of a len-beat packet; called at posedge+1.
  task automatic send_pkt(input int len, input int slen,
                          input int nsend,
                          input int stall_beat,
                          input int stall_cyc,
                          input int pct);
    int  w;
    int  b0;
    int  b1;
    int  exp0;
    bit  to_m1;
    bit  lastb;
    bit  exp_l0;
    bit  acc;
    b0 = mon0;
    b1 = mon1;
    split_len = slen[15:0];
    for (int i = 0; i < nsend; i++) begin
      to_m1  = (slen != 0) && (i >= slen);
      lastb  = (i == len - 1);
      exp_l0 = lastb || ((slen != 0) && (i == slen - 1));
      s_if.tdata  = $urandom;
      s_if.tkeep  = 4'($urandom_range(15));
      s_if.tuser  = 1'($urandom_range(1));
      s_if.tlast  = lastb;
      s_if.tvalid = 1'b1;
      w = 0;
      forever begin
        m0_if.tready = (w >= 8) || ($urandom_range(99) < pct);
        m1_if.tready = (w >= 8) || ($urandom_range(99) < pct);
        if (i == stall_beat && w < stall_cyc)
          m0_if.tready = 1'b0;
        acc = to_m1 ? m1_if.tready : m0_if.tready;
        @(negedge aclk);
        chk("m0_tvalid", 64'(m0_if.tvalid), 64'(!to_m1));
        chk("m1_tvalid", 64'(m1_if.tvalid), 64'(to_m1));
        chk("m0_tdata", 64'(m0_if.tdata), 64'(s_if.tdata));
        chk("m1_tdata", 64'(m1_if.tdata), 64'(s_if.tdata));
        chk("m0_tkeep", 64'(m0_if.tkeep), 64'(s_if.tkeep));
        chk("m1_tuser", 64'(m1_if.tuser), 64'(s_if.tuser));
        if (!to_m1)
          chk("m0_tlast", 64'(m0_if.tlast), 64'(exp_l0));
        chk("m1_tlast", 64'(m1_if.tlast), 64'(lastb));
        chk("s_tready", 64'(s_if.tready), 64'(acc));
        @(posedge aclk);
        #1;
        if (acc) break;
        w++;
        if (w > 40) begin
          failures++;
          $error("FAIL timeout beat=%0d got=stalled exp=accept", i);
          break;
        end
      end
    end
    s_if.tvalid = 1'b0;
    if (nsend == len) begin
      exp0 = (slen == 0 || len < slen) ? len : slen;
      chk("m0_beats", 64'(mon0 - b0), 64'(exp0));
      chk("m1_beats", 64'(mon1 - b1), 64'(len - exp0));
    end
  endtask

  initial begin
    int rl;
    int rs;
    rst          = 1'b1;
    split_len    = 16'd4;
    s_if.tdata   = 32'h1234_5678;
    s_if.tkeep   = 4'hF;
    s_if.tuser   = 1'b0;
    s_if.tlast   = 1'b0;
    s_if.tvalid  = 1'b1;
    m0_if.tready = 1'b1;
    m1_if.tready = 1'b0;

    // reset state: routing with sel=0
    #12;
    chk("rst_m0_tvalid", 64'(m0_if.tvalid), 64'd1);
    chk("rst_m1_tvalid", 64'(m1_if.tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd1);
    m0_if.tready = 1'b0;
    m1_if.tready = 1'b1;
    #1;
    chk("rst_s_tready_sel", 64'(s_if.tready), 64'd0);
    @(negedge aclk);
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    @(posedge aclk);
    #1;

    send_pkt(10, 4, 10, -1, 0, 100);
    send_pkt(5, 8, 5, -1, 0, 100);
    send_pkt(3, 8, 3, -1, 0, 100);
    send_pkt(3, 1, 3, -1, 0, 100);
    send_pkt(10, 4, 10, 2, 3, 50);
    send_pkt(6, 2, 6, -1, 0, 70);
    send_pkt(3, 2, 3, -1, 0, 70);
    send_pkt(4, 4, 4, -1, 0, 80);
    send_pkt(7, 0, 7, -1, 0, 80);

    // reset in the middle of the m1 portion
    send_pkt(10, 3, 5, -1, 0, 100);
    s_if.tdata   = $urandom;
    s_if.tlast   = 1'b0;
    s_if.tvalid  = 1'b1;
    m0_if.tready = 1'b1;
    m1_if.tready = 1'b1;
    #1;
    chk("pre_rst_m1_tvalid", 64'(m1_if.tvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_m1_tvalid", 64'(m1_if.tvalid), 64'd0);
    chk("mid_rst_m0_tvalid", 64'(m0_if.tvalid), 64'd1);
    @(negedge aclk);
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    @(posedge aclk);
    #1;
    send_pkt(4, 3, 4, -1, 0, 100);

    for (int k = 0; k < 8; k++) begin
      rl = int'($urandom_range(12, 1));
      rs = int'($urandom_range(6, 0));
      send_pkt(rl, rs, rl, -1, 0, 60);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
